e6_pwm_multi: RTL
=================

Name: e6_pwm_multi

Overview:
Multi-channel PWM generator with an AXI4-Lite slave register interface. It is the parametrised successor of the single-channel E6 PWM peripheral. Channel count and counter width are set by parameters. Each channel adds double-buffered PERIOD/DUTY registers, output polarity control and sticky period-wrap flags. The block sits behind the AXI interconnect; its pwm_out pins go to the board.

Parameters:
NUM_CH, 4, number of PWM channels (1..8)
CNT_W, 16, counter/PERIOD/DUTY width in bits (2..32)
C_S_AXI_ADDR_WIDTH, 7, byte address width (must cover 0x10 + 8*NUM_CH)
C_S_AXI_DATA_WIDTH, 32, AXI data width (fixed at 32)

Ports:
ACLK  in  1  clock
ARESET  in  1  synchronous active-high reset
S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address
S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  write address handshake
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte strobes
S_AXI_WVALID / S_AXI_WREADY  in/out  1  write data handshake
S_AXI_BRESP  out  2  write response
S_AXI_BVALID / S_AXI_BREADY  out/in  1  write response handshake
S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address
S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  read address handshake
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  read response
S_AXI_RVALID / S_AXI_RREADY  out/in  1  read data handshake
pwm_out  out  NUM_CH  PWM outputs, bit k = channel k
irq  out  1  OR of (STATUS & IRQ_EN)

Behaviour:
- Clock and reset: one clock, ACLK. Reset is synchronous, active-high, on ARESET.
- Reset values: all registers 0; AWREADY/WREADY/BVALID/ARREADY/RVALID = 0; RDATA = 0; BRESP/RRESP = 0; pwm_out = 0; irq = 0.
- Register map (byte offsets, word aligned):
  - 0x00 CTRL rw: [NUM_CH-1:0] channel enable.
  - 0x04 POL rw: [NUM_CH-1:0] invert.
  - 0x08 STATUS: [NUM_CH-1:0] wrap flags, write-1-to-clear.
  - 0x0C IRQ_EN rw: [NUM_CH-1:0].
  - 0x10+8k PERIOD_k (shadow) rw.
  - 0x14+8k DUTY_k (shadow) rw, [CNT_W-1:0].
  - Unused bits read 0.
- AXI write:
  - AWREADY and WREADY pulse together for exactly one cycle, only when AWVALID & WVALID are both high and BVALID = 0.
  - Register update occurs in that same cycle, honouring WSTRB per byte.
  - BVALID rises the next cycle and holds until BREADY.
- AXI read:
  - ARREADY pulses one cycle when ARVALID is high and RVALID = 0.
  - RVALID and RDATA are valid the next cycle and held stable until RREADY.
- Read and write paths are independent. Only one transaction is outstanding per path.
- Address decode: an offset at or beyond 0x10+8*NUM_CH returns SLVERR (2'b10). A write there has no effect; a read there returns 0. All other accesses return OKAY.
- Reads of PERIOD_k/DUTY_k return the shadow value, not the active value.
- Per-channel counter cnt_k, CNT_W bits:
  - Channel disabled: cnt_k held at 0; active PERIOD/DUTY continuously loaded from shadow; pwm_out[k] = POL[k].
  - Channel enabled: cnt_k increments each cycle. When cnt_k == PERIOD_act_k it wraps to 0 the next cycle, so the period is PERIOD+1 cycles.
  - On that wrap cycle, PERIOD_act/DUTY_act load from shadow and STATUS[k] sets.
- Raw output: raw_k = (cnt_k < DUTY_act_k), registered. pwm_out[k] = raw_k XOR POL[k]. Output latency is one cycle after cnt_k.
- Duty boundaries:
  - DUTY = 0 gives constant low (pre-polarity).
  - DUTY > PERIOD gives constant high.
  - PERIOD = 0 gives a wrap every cycle.
- Enable edge: enabling a channel starts it from cnt = 0 with the values currently in shadow.
- Simultaneous events:
  - Wrap set and W1C on the same STATUS bit in the same cycle: set wins.
  - Shadow write in the same cycle as a load: the active register takes the old shadow; the new value applies at the next wrap.
- irq is registered: irq = |(STATUS & IRQ_EN), one cycle after a STATUS change.
- ARESET mid-transaction drops all VALID/READY outputs to 0 the next cycle and abandons in-flight transfers.

Test Plan:
- Reset then reads of all registers → all read 0; pwm_out = 0; irq = 0. Read at 0x10+8*NUM_CH → RRESP = 2'b10, RDATA = 0.
- Ch0: PERIOD = 9, DUTY = 3, POL = 0, CTRL = 0x1 → pwm_out[0] repeats 3 high / 7 low. Period measured as exactly 10 ACLK.
- Ch0 running at PERIOD = 9/DUTY = 3; write DUTY = 7 mid-period → current period keeps 3 high; the next period starts with 7 high. Readback of DUTY returns 7 immediately.
- Boundary values: DUTY = 0 → constant 0. DUTY = 10 with PERIOD = 9 → constant 1. POL[1] = 1 with ch1 disabled → pwm_out[1] = 1.
- IRQ_EN = 0x1, ch0 enabled → STATUS[0] = 1 after the first wrap and irq = 1 one cycle later. Write STATUS = 0x1 → irq = 0; it reasserts at the next wrap.
- AW presented 5 cycles before W, and BREADY held low 4 cycles → no AWREADY until WVALID is high; BVALID held for 4 cycles; no second write accepted while BVALID = 1. WSTRB = 4'b0001 with data 0xFFFF_FFAA to PERIOD_0 (0x0000_1234) → 0x0000_12AA.

Source files
------------

// File: rtl/e6_pwm_multi.sv
// e6_pwm_multi: NUM_CH-channel PWM with double-buffered PERIOD/DUTY, polarity and sticky wrap flags behind AXI4-Lite
module e6_pwm_multi #(
    parameter int NUM_CH             = 4,
    parameter int CNT_W              = 16,
    parameter int C_S_AXI_ADDR_WIDTH = 7,
    parameter int C_S_AXI_DATA_WIDTH = 32
) (
    input  logic                          ACLK,
    input  logic                          ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
    input  logic                          S_AXI_AWVALID,
    output logic                          S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_WDATA,
    input  logic [3:0]                    S_AXI_WSTRB,
    input  logic                          S_AXI_WVALID,
    output logic                          S_AXI_WREADY,
    output logic [1:0]                    S_AXI_BRESP,
    output logic                          S_AXI_BVALID,
    input  logic                          S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic                          S_AXI_ARVALID,
    output logic                          S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_RDATA,
    output logic [1:0]                    S_AXI_RRESP,
    output logic                          S_AXI_RVALID,
    input  logic                          S_AXI_RREADY,
    output logic [NUM_CH-1:0]             pwm_out,
    output logic                          irq
);
    localparam int AW = C_S_AXI_ADDR_WIDTH;
    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int WW = AW - 2;
    localparam logic [AW-1:0] TOP = AW'(16 + 8 * NUM_CH);

    logic [NUM_CH-1:0] ctrl_q, pol_q, status_q, status_d, irq_en_q, raw_q, wrap, w1c;
    logic [CNT_W-1:0]  per_sh_q [NUM_CH];
    logic [CNT_W-1:0]  duty_sh_q [NUM_CH];
    logic [CNT_W-1:0]  per_act_q [NUM_CH];
    logic [CNT_W-1:0]  duty_act_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic              awready_q, bvalid_q, arready_q, rvalid_q, irq_q;
    logic [1:0]        bresp_q, rresp_q;
    logic [DW-1:0]     rdata_q, rdata_d, wmask;
    logic [WW-1:0]     aw_w, ar_w;
    logic              wr_hs, wr_en, rd_hs, wr_ok, rd_ok;

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                            input logic [DW-1:0] m);
        return (old & ~m) | (d & m);
    endfunction

    assign aw_w  = S_AXI_AWADDR[AW-1:2];
    assign ar_w  = S_AXI_ARADDR[AW-1:2];
    assign wr_ok = S_AXI_AWADDR < TOP;
    assign rd_ok = S_AXI_ARADDR < TOP;
    assign wr_hs = awready_q & S_AXI_AWVALID & S_AXI_WVALID;
    assign wr_en = wr_hs & wr_ok;
    assign rd_hs = arready_q & S_AXI_ARVALID;

    always_comb begin
        for (int b = 0; b < 4; b++) wmask[8*b +: 8] = {8{S_AXI_WSTRB[b]}};
        w1c = (wr_en && aw_w == WW'(2)) ? NUM_CH'(S_AXI_WDATA & wmask) : '0;
        for (int k = 0; k < NUM_CH; k++) wrap[k] = ctrl_q[k] && cnt_q[k] == per_act_q[k];
        // a wrap in the same cycle as a clear keeps the flag set
        status_d = (status_q & ~w1c) | wrap;
        rdata_d = ar_w == WW'(0) ? DW'(ctrl_q) :
                  ar_w == WW'(1) ? DW'(pol_q) :
                  ar_w == WW'(2) ? DW'(status_q) :
                  ar_w == WW'(3) ? DW'(irq_en_q) : '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (ar_w == WW'(4 + 2 * k)) rdata_d = DW'(per_sh_q[k]);
            if (ar_w == WW'(5 + 2 * k)) rdata_d = DW'(duty_sh_q[k]);
        end
        if (!rd_ok) rdata_d = '0;
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            {ctrl_q, pol_q, status_q, irq_en_q, raw_q} <= '0;
            {awready_q, bvalid_q, arready_q, rvalid_q, irq_q} <= '0;
            {bresp_q, rresp_q} <= '0;
            rdata_q <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                per_sh_q[k]   <= '0;
                duty_sh_q[k]  <= '0;
                per_act_q[k]  <= '0;
                duty_act_q[k] <= '0;
                cnt_q[k]      <= '0;
            end
        end else begin
            awready_q <= ~awready_q & ~bvalid_q & S_AXI_AWVALID & S_AXI_WVALID;
            if (wr_hs) begin
                bvalid_q <= 1'b1;
                bresp_q  <= wr_ok ? 2'b00 : 2'b10;
            end else if (S_AXI_BREADY) bvalid_q <= 1'b0;
            arready_q <= ~arready_q & ~rvalid_q & S_AXI_ARVALID;
            if (rd_hs) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rdata_d;
                rresp_q  <= rd_ok ? 2'b00 : 2'b10;
            end else if (S_AXI_RREADY) rvalid_q <= 1'b0;
            if (wr_en && aw_w == WW'(0)) ctrl_q <= NUM_CH'(merge(DW'(ctrl_q), S_AXI_WDATA, wmask));
            if (wr_en && aw_w == WW'(1)) pol_q <= NUM_CH'(merge(DW'(pol_q), S_AXI_WDATA, wmask));
            if (wr_en && aw_w == WW'(3)) irq_en_q <= NUM_CH'(merge(DW'(irq_en_q), S_AXI_WDATA, wmask));
            status_q <= status_d;
            irq_q    <= |(status_q & irq_en_q);
            for (int k = 0; k < NUM_CH; k++) begin
                if (wr_en && aw_w == WW'(4 + 2 * k))
                    per_sh_q[k] <= CNT_W'(merge(DW'(per_sh_q[k]), S_AXI_WDATA, wmask));
                if (wr_en && aw_w == WW'(5 + 2 * k))
                    duty_sh_q[k] <= CNT_W'(merge(DW'(duty_sh_q[k]), S_AXI_WDATA, wmask));
                // idle channels track the shadows so enabling starts from fresh values
                if (!ctrl_q[k] || wrap[k]) begin
                    per_act_q[k]  <= per_sh_q[k];
                    duty_act_q[k] <= duty_sh_q[k];
                end
                cnt_q[k] <= (!ctrl_q[k] || wrap[k]) ? '0 : cnt_q[k] + CNT_W'(1);
                raw_q[k] <= ctrl_q[k] && cnt_q[k] < duty_act_q[k];
            end
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = awready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign pwm_out       = raw_q ^ pol_q;
    assign irq           = irq_q;
endmodule
